// File: rtl/vga2_pixsrc_pipe.sv
// Two-stage pixel-source pipeline: texel byte address or alpha-blended solid colour, 1 pixel/cycle.
// Optional texture coordinate wrap via `define VGA2_PIXSRC_WRAP_EN.
module vga2_pixsrc_pipe #(
   parameter int ADDR_W = 26,
   parameter int X_W    = 10,
   parameter int Z_W    = 12,
   parameter int UV_W   = 12,
   parameter int MODE_W = 5
) (
   input  logic              clock,
   input  logic              reset,
   output logic              pixsrc_ready,
   input  logic              pixsrc_valid,
   input  logic [X_W-1:0]    pixsrc_x,
   input  logic [Z_W-1:0]    pixsrc_z,
   input  logic [UV_W-1:0]   pixsrc_u,
   input  logic [UV_W-1:0]   pixsrc_v,
   input  logic [MODE_W-1:0] pixsrc_mode,
   input  logic [31:0]       pixsrc_src_addr,
   input  logic [31:0]       pixsrc_src_stride,
   input  logic              memread_ready,
   output logic              memread_valid,
   output logic [X_W-1:0]    memread_x,
   output logic [Z_W-1:0]    memread_z,
   output logic [MODE_W-1:0] memread_mode,
   output logic [ADDR_W-1:0] memread_addr
);

   localparam int PROD_W = 16 + UV_W;

   logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
   logic s1_adv, s2_adv, s1_load, s2_load;

   logic [X_W-1:0]    s1_x_q, s1_x_d, s2_x_q, s2_x_d;
   logic [Z_W-1:0]    s1_z_q, s1_z_d, s2_z_q, s2_z_d;
   logic [MODE_W-1:0] s1_mode_q, s1_mode_d, s2_mode_q, s2_mode_d;
   logic [ADDR_W-1:0] s1_base_q, s1_base_d, s2_addr_q, s2_addr_d;
   logic [UV_W-1:0]   s1_u_q, s1_u_d;
   logic [PROD_W-1:0] s1_prod_q, s1_prod_d;
   logic [2:0][15:0]  s1_t_q, s1_t_d;

   logic [UV_W-1:0]   u_tex, v_tex;
   logic [7:0]        alpha, inv_alpha;
   logic [ADDR_W-1:0] tex_sum, tex_addr, solid_addr;
   logic [2:0][7:0]   chan;
   logic [16:0]       t_rnd;

   // Handshake: each stage advances when the one after it can take its contents.
   always_comb begin
      s2_adv       = memread_ready || !s2_valid_q;
      s1_adv       = s2_adv || !s1_valid_q;
      s1_load      = s1_adv && pixsrc_valid;
      s2_load      = s2_adv && s1_valid_q;
      s1_valid_d   = s1_adv ? pixsrc_valid : s1_valid_q;
      s2_valid_d   = s2_adv ? s1_valid_q : s2_valid_q;
      pixsrc_ready = s1_adv;
   end

`ifdef VGA2_PIXSRC_WRAP_EN
   always_comb begin
      u_tex = pixsrc_u;
      v_tex = pixsrc_v;
      if (pixsrc_src_stride[31:28] != 4'd0)
         u_tex = pixsrc_u & ~({UV_W{1'b1}} << pixsrc_src_stride[31:28]);
      if (pixsrc_src_stride[27:24] != 4'd0)
         v_tex = pixsrc_v & ~({UV_W{1'b1}} << pixsrc_src_stride[27:24]);
   end
   logic unused_bits;
   assign unused_bits = ^pixsrc_src_addr[31:ADDR_W];
`else
   assign u_tex = pixsrc_u;
   assign v_tex = pixsrc_v;
   logic unused_bits;
   assign unused_bits = ^{pixsrc_src_addr[31:ADDR_W], pixsrc_src_stride[31:24]};
`endif

   // S1: capture sideband and register the multiplies for both modes.
   always_comb begin
      s1_x_d    = s1_x_q;
      s1_z_d    = s1_z_q;
      s1_mode_d = s1_mode_q;
      s1_base_d = s1_base_q;
      s1_u_d    = s1_u_q;
      s1_prod_d = s1_prod_q;
      s1_t_d    = s1_t_q;
      alpha     = pixsrc_u[7:0];
      inv_alpha = 8'd255 - alpha;
      if (s1_load) begin
         s1_x_d    = pixsrc_x;
         s1_z_d    = pixsrc_z;
         s1_mode_d = pixsrc_mode;
         s1_base_d = pixsrc_src_addr[ADDR_W-1:0];
         s1_u_d    = u_tex;
         s1_prod_d = PROD_W'(pixsrc_src_stride[15:0]) * PROD_W'(v_tex);
         for (int ch = 0; ch < 3; ch++) begin
            s1_t_d[ch] = 16'(pixsrc_src_addr[8*ch +: 8]) * 16'(alpha)
                       + 16'(pixsrc_src_stride[8*ch +: 8]) * 16'(inv_alpha);
         end
      end
   end

   // S2: texel offset scaling and rounded divide-by-255 of the blend sums.
   always_comb begin
      tex_sum = ADDR_W'(s1_prod_q) + ADDR_W'(s1_u_q);
      unique case (s1_mode_q[2:1])
         2'b00:   tex_addr = s1_base_q + tex_sum;
         2'b01:   tex_addr = s1_base_q + (tex_sum << 1);
         default: tex_addr = s1_base_q + (tex_sum << 2);
      endcase
      chan  = '0;
      t_rnd = '0;
      for (int ch = 0; ch < 3; ch++) begin
         t_rnd    = 17'(s1_t_q[ch]) + 17'd128;
         chan[ch] = 8'((t_rnd + (t_rnd >> 8)) >> 8);
      end
      solid_addr = ADDR_W'(chan);

      s2_x_d    = s2_x_q;
      s2_z_d    = s2_z_q;
      s2_mode_d = s2_mode_q;
      s2_addr_d = s2_addr_q;
      if (s2_load) begin
         s2_x_d    = s1_x_q;
         s2_z_d    = s1_z_q;
         s2_mode_d = s1_mode_q;
         s2_addr_d = s1_mode_q[0] ? solid_addr : tex_addr;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
      end
   end

   // NOTE: payload flops are deliberately unreset; the valid bits alone qualify them.
   always_ff @(posedge clock) begin
      s1_x_q    <= s1_x_d;
      s1_z_q    <= s1_z_d;
      s1_mode_q <= s1_mode_d;
      s1_base_q <= s1_base_d;
      s1_u_q    <= s1_u_d;
      s1_prod_q <= s1_prod_d;
      s1_t_q    <= s1_t_d;
      s2_x_q    <= s2_x_d;
      s2_z_q    <= s2_z_d;
      s2_mode_q <= s2_mode_d;
      s2_addr_q <= s2_addr_d;
   end

   assign memread_valid = s2_valid_q;
   assign memread_x     = s2_x_q;
   assign memread_z     = s2_z_q;
   assign memread_mode  = s2_mode_q;
   assign memread_addr  = s2_addr_q;

endmodule
